// File: rtl/wb_sdram_port_arbiter_if.sv
// Bundle of the per-port Wishbone masters and the single SDRAM controller port.
// The arbiter uses the slave modport; the surrounding fabric uses the master modport.
interface wb_sdram_port_arbiter_if #(
  parameter int WB_PORTS = 2,
  parameter int AW       = 32,
  parameter int DW       = 32
);
  logic [WB_PORTS*AW-1:0]     wb_adr_i;
  logic [WB_PORTS*DW-1:0]     wb_dat_i;
  logic [WB_PORTS*DW/8-1:0]   wb_sel_i;
  logic [WB_PORTS-1:0]        wb_we_i;
  logic [WB_PORTS-1:0]        wb_cyc_i;
  logic [WB_PORTS-1:0]        wb_stb_i;
  logic [WB_PORTS*3-1:0]      wb_cti_i;
  logic [WB_PORTS*2-1:0]      wb_bte_i;
  logic [WB_PORTS*DW-1:0]     wb_dat_o;
  logic [WB_PORTS-1:0]        wb_ack_o;

  logic [AW-1:0]              m_adr_o;
  logic [DW-1:0]              m_dat_o;
  logic [DW/8-1:0]            m_sel_o;
  logic                       m_we_o;
  logic                       m_cyc_o;
  logic                       m_stb_o;
  logic [2:0]                 m_cti_o;
  logic [1:0]                 m_bte_o;
  logic [DW-1:0]              m_dat_i;
  logic                       m_ack_i;

  logic [WB_PORTS-1:0]        grant_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  m_dat_i, m_ack_i,
    output wb_dat_o, wb_ack_o,
    output m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o, m_cti_o, m_bte_o,
    output grant_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output m_dat_i, m_ack_i,
    input  wb_dat_o, wb_ack_o,
    input  m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o, m_cti_o, m_bte_o,
    input  grant_o
  );
endinterface

// File: rtl/wb_sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller Wishbone slave among WB_PORTS masters.
// A grant is held for the whole Wishbone cycle (bursts included), then priority rotates.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; m_* held at 0; picks next requester after last
// BUSY  | grant held; m_* muxed from granted port until end of cycle
module wb_sdram_port_arbiter #(
  parameter int WB_PORTS = 2,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input logic                  wb_clk,
  input logic                  wb_rst,
  wb_sdram_port_arbiter_if.slave bus
);

  localparam int IW = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       gidx, gidx_nxt;
  logic [IW-1:0]       last, last_nxt;
  logic [WB_PORTS-1:0] grant, grant_nxt;
  logic [WB_PORTS-1:0] req;

  logic                pick_vld;
  logic [IW-1:0]       pick;
  logic [IW:0]         cand;

  logic [AW-1:0]       g_adr;
  logic [DW-1:0]       g_dat;
  logic [DW/8-1:0]     g_sel;
  logic                g_we;
  logic                g_cyc;
  logic                g_stb;
  logic [2:0]          g_cti;
  logic [1:0]          g_bte;
  logic                release_c;

  assign req = bus.wb_cyc_i & bus.wb_stb_i;

  // Scan from last+1 upward with wrap-around; first requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = 1; k <= WB_PORTS; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(WB_PORTS))
        cand = cand - (IW+1)'(WB_PORTS);
      if (!pick_vld && req[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_cti = '0;
    g_bte = '0;
    for (int i = 0; i < WB_PORTS; i++) begin
      if (gidx == IW'(i)) begin
        g_adr = bus.wb_adr_i[i*AW +: AW];
        g_dat = bus.wb_dat_i[i*DW +: DW];
        g_sel = bus.wb_sel_i[i*(DW/8) +: (DW/8)];
        g_we  = bus.wb_we_i[i];
        g_cyc = bus.wb_cyc_i[i];
        g_stb = bus.wb_stb_i[i];
        g_cti = bus.wb_cti_i[i*3 +: 3];
        g_bte = bus.wb_bte_i[i*2 +: 2];
      end
    end
  end

  // Classic cycle or end-of-burst ack finishes the cycle; a dropped cyc abandons it.
  assign release_c = (state == BUSY) &&
                     ((bus.m_ack_i && (g_cti == 3'b000 || g_cti == 3'b111)) || !g_cyc);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= IW'(WB_PORTS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      gidx  <= gidx_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gidx_nxt  = gidx;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = BUSY;
          gidx_nxt  = pick;
          grant_nxt = WB_PORTS'(1) << pick;
        end
      end
      BUSY: begin
        if (release_c) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = gidx;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State resets asynchronously, so every controller-side output drops with wb_rst.
  always_comb begin
    bus.m_adr_o  = '0;
    bus.m_dat_o  = '0;
    bus.m_sel_o  = '0;
    bus.m_we_o   = 1'b0;
    bus.m_cyc_o  = 1'b0;
    bus.m_stb_o  = 1'b0;
    bus.m_cti_o  = '0;
    bus.m_bte_o  = '0;
    bus.wb_ack_o = '0;
    if (state == BUSY) begin
      bus.m_adr_o  = g_adr;
      bus.m_dat_o  = g_dat;
      bus.m_sel_o  = g_sel;
      bus.m_we_o   = g_we;
      bus.m_cyc_o  = g_cyc;
      bus.m_stb_o  = g_stb;
      bus.m_cti_o  = g_cti;
      bus.m_bte_o  = g_bte;
      bus.wb_ack_o = grant & {WB_PORTS{bus.m_ack_i}};
    end
  end

  assign bus.wb_dat_o = {WB_PORTS{bus.m_dat_i}};
  assign bus.grant_o  = grant;

endmodule

// File: tb/tb_wb_sdram_port_arbiter.sv
// Directed bench for the two-port SDRAM Wishbone arbiter: singles, bursts,
// aborted burst, reset mid-cycle and round-robin alternation.
module tb_wb_sdram_port_arbiter;

  logic wb_clk;
  logic wb_rst;
  int   total;
  int   passed;

  wb_sdram_port_arbiter_if #(.WB_PORTS(2), .AW(32), .DW(32)) bus ();

  wb_sdram_port_arbiter #(.WB_PORTS(2), .AW(32), .DW(32)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #2;
  endtask

  task automatic set_port(input int p, input logic cyc, input logic stb, input logic we,
                          input logic [2:0] cti, input logic [31:0] adr, input logic [31:0] dat);
    bus.wb_cyc_i[p]         = cyc;
    bus.wb_stb_i[p]         = stb;
    bus.wb_we_i[p]          = we;
    bus.wb_cti_i[p*3 +: 3]  = cti;
    bus.wb_adr_i[p*32 +: 32] = adr;
    bus.wb_dat_i[p*32 +: 32] = dat;
    bus.wb_sel_i[p*4 +: 4]  = 4'hF;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    wb_rst = 1'b1;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0; bus.wb_we_i = '0;
    bus.wb_cyc_i = '0; bus.wb_stb_i = '0; bus.wb_cti_i = '0; bus.wb_bte_i = '0;
    bus.m_dat_i  = '0; bus.m_ack_i  = 1'b0;

    // reset state
    tick(); tick(); #1;
    chk("rst_grant", 64'(bus.grant_o), 64'h0);
    chk("rst_cyc",   64'(bus.m_cyc_o), 64'h0);
    chk("rst_ack",   64'(bus.wb_ack_o), 64'h0);
    chk("rst_adr",   64'(bus.m_adr_o), 64'h0);
    wb_rst = 1'b0;

    // port0 single read, ack three cycles in
    set_port(0, 1, 1, 0, 3'b000, 32'h100, 32'h0);
    #1 chk("t1_cyc_pre", 64'(bus.m_cyc_o), 64'h0);
    tick(); #1;
    chk("t1_cyc",   64'(bus.m_cyc_o), 64'h1);
    chk("t1_grant", 64'(bus.grant_o), 64'h1);
    chk("t1_adr",   64'(bus.m_adr_o), 64'h100);
    tick(); tick(); #1;
    chk("t1_noack", 64'(bus.wb_ack_o), 64'h0);
    tick();
    bus.m_ack_i = 1'b1; bus.m_dat_i = 32'hDEADBEEF;
    #1;
    chk("t1_ack", 64'(bus.wb_ack_o), 64'h1);
    chk("t1_dat", 64'(bus.wb_dat_o), 64'hDEADBEEF_DEADBEEF);
    tick();
    bus.m_ack_i = 1'b0;
    set_port(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("t1_idle_grant", 64'(bus.grant_o), 64'h0);
    chk("t1_idle_cyc",   64'(bus.m_cyc_o), 64'h0);

    // simultaneous single writes after a fresh reset
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    set_port(0, 1, 1, 1, 3'b000, 32'h200, 32'h11111111);
    set_port(1, 1, 1, 1, 3'b000, 32'h300, 32'h22222222);
    #1 chk("t2_grant_pre", 64'(bus.grant_o), 64'h0);
    tick(); #1;
    chk("t2_grant0", 64'(bus.grant_o), 64'h1);
    chk("t2_adr0",   64'(bus.m_adr_o), 64'h200);
    chk("t2_dat0",   64'(bus.m_dat_o), 64'h11111111);
    chk("t2_we0",    64'(bus.m_we_o),  64'h1);
    bus.m_ack_i = 1'b1;
    #1 chk("t2_ack0", 64'(bus.wb_ack_o), 64'h1);
    tick();
    bus.m_ack_i = 1'b0;
    set_port(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    #1 chk("t2_gap", 64'(bus.grant_o), 64'h0);
    tick(); #1;
    chk("t2_grant1", 64'(bus.grant_o), 64'h2);
    chk("t2_adr1",   64'(bus.m_adr_o), 64'h300);
    chk("t2_dat1",   64'(bus.m_dat_o), 64'h22222222);
    bus.m_ack_i = 1'b1;
    #1 chk("t2_ack1", 64'(bus.wb_ack_o), 64'h2);
    tick();
    bus.m_ack_i = 1'b0;
    set_port(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    #1 chk("t2_end", 64'(bus.grant_o), 64'h0);

    // port1 4-beat incrementing burst while port0 keeps requesting
    set_port(1, 1, 1, 0, 3'b010, 32'h400, 32'h0);
    bus.wb_bte_i[3:2] = 2'b01;
    tick(); #1;
    chk("t3_grant", 64'(bus.grant_o), 64'h2);
    chk("t3_bte",   64'(bus.m_bte_o), 64'h1);
    set_port(0, 1, 1, 0, 3'b000, 32'h500, 32'h0);
    for (int b = 0; b < 4; b++) begin
      set_port(1, 1, 1, 0, (b == 3) ? 3'b111 : 3'b010, 32'h400 + 32'(4*b), 32'h0);
      bus.m_ack_i = 1'b1;
      #1;
      chk("t3_beat_grant", 64'(bus.grant_o), 64'h2);
      chk("t3_beat_ack",   64'(bus.wb_ack_o), 64'h2);
      chk("t3_beat_adr",   64'(bus.m_adr_o), 64'(32'h400 + 32'(4*b)));
      tick();
    end
    bus.m_ack_i = 1'b0;
    set_port(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    bus.wb_bte_i[3:2] = 2'b00;
    #1 chk("t3_gap", 64'(bus.grant_o), 64'h0);
    tick(); #1;
    chk("t3_grant0", 64'(bus.grant_o), 64'h1);
    chk("t3_adr0",   64'(bus.m_adr_o), 64'h500);
    bus.m_ack_i = 1'b1;
    tick();
    bus.m_ack_i = 1'b0;
    set_port(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    #1 chk("t3_end", 64'(bus.grant_o), 64'h0);

    // port0 abandons a burst after beat 2
    tick();
    set_port(0, 1, 1, 0, 3'b010, 32'h600, 32'h0);
    tick(); #1;
    chk("t4_grant", 64'(bus.grant_o), 64'h1);
    bus.m_ack_i = 1'b1;
    tick();
    set_port(0, 1, 1, 0, 3'b010, 32'h604, 32'h0);
    tick();
    bus.m_ack_i = 1'b0;
    set_port(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("t4_cyc_drop", 64'(bus.m_cyc_o), 64'h0);
    chk("t4_stb_drop", 64'(bus.m_stb_o), 64'h0);
    tick(); #1;
    chk("t4_idle", 64'(bus.grant_o), 64'h0);
    bus.m_ack_i = 1'b1;
    #1 chk("t4_stray_ack", 64'(bus.wb_ack_o), 64'h0);
    bus.m_ack_i = 1'b0;

    // reset while port1 owns the bus
    tick();
    set_port(1, 1, 1, 0, 3'b000, 32'h700, 32'h33333333);
    tick(); #1;
    chk("t5_grant", 64'(bus.grant_o), 64'h2);
    chk("t5_cyc",   64'(bus.m_cyc_o), 64'h1);
    set_port(0, 1, 1, 0, 3'b000, 32'h800, 32'h0);
    bus.m_ack_i = 1'b1;
    wb_rst = 1'b1;
    #1;
    chk("t5_rst_cyc",   64'(bus.m_cyc_o), 64'h0);
    chk("t5_rst_stb",   64'(bus.m_stb_o), 64'h0);
    chk("t5_rst_grant", 64'(bus.grant_o), 64'h0);
    chk("t5_rst_ack",   64'(bus.wb_ack_o), 64'h0);
    bus.m_ack_i = 1'b0;
    tick();
    wb_rst = 1'b0;
    #1 chk("t5_post_rst", 64'(bus.grant_o), 64'h0);
    tick();

    // both ports request continuously: 0,1,0,1,... with one idle cycle between
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t6_grant", 64'(bus.grant_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      chk("t6_adr",   64'(bus.m_adr_o), (k % 2 == 0) ? 64'h800 : 64'h700);
      bus.m_ack_i = 1'b1;
      #1 chk("t6_ack", 64'(bus.wb_ack_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      bus.m_ack_i = 1'b0;
      #1;
      chk("t6_gap_grant", 64'(bus.grant_o), 64'h0);
      chk("t6_gap_cyc",   64'(bus.m_cyc_o), 64'h0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
